// File: rtl/run_length_segmenter_pkg.sv
// Shared definitions for the JPEG-LS run-mode segmenter: widths, the J table
// lookup and the segmenter FSM state encoding.
package run_length_segmenter_pkg;

    localparam int runindex_length = 5;
    localparam int runcount_length = 16;
    localparam int tok_width       = runcount_length + 1;
    localparam int j_width         = 4;
    localparam int tok_len_width   = 5;

    localparam logic [runindex_length-1:0] runindex_max = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEG,
        ST_EOL,
        ST_INT,
        ST_FIN
    } seg_state_t;

    // J table 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8..15:
    // indices 0..15 step every 4, 16..23 every 2, 24..31 every entry.
    function automatic logic [j_width-1:0] j_lookup(input logic [runindex_length-1:0] idx);
        logic [j_width-1:0] j;
        if (!idx[4]) begin
            j = {2'b00, idx[3:2]};
        end else if (!idx[3]) begin
            j = {2'b01, idx[2:1]};
        end else begin
            j = {1'b1, idx[2:0]};
        end
        return j;
    endfunction

endpackage

// File: rtl/run_length_segmenter_j_table.sv
// RUNindex -> J and rm = 2^J. Purely combinational so the decoder-side run
// stage can share it.
module run_j_table
    import run_length_segmenter_pkg::*;
(
    input  logic [runindex_length-1:0] run_index,
    output logic [j_width-1:0]         j,
    output logic [runcount_length-1:0] rm
);

    // Table lookup and segment size
    always_comb begin
        j  = j_lookup(run_index);
        rm = runcount_length'(1) << j;
    end

endmodule

// File: rtl/run_length_segmenter.sv
// JPEG-LS run-mode segmenter: splits a completed run into J-table segments
// and emits one token per cycle ('1' per segment, then the EOL '1' or the
// interruption '0'+remainder). Owns RUNindex across runs.
module run_length_segmenter
    import run_length_segmenter_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       index_clear,
    input  logic                       run_valid,
    output logic                       run_ready,
    input  logic [runcount_length-1:0] run_length,
    input  logic                       run_eol,
    output logic                       tok_valid,
    input  logic                       tok_ready,
    output logic [tok_width-1:0]       tok_bits,
    output logic [tok_len_width-1:0]   tok_len,
    output logic [runindex_length-1:0] run_index,
    output logic                       run_done
);

    localparam logic [runcount_length-1:0] rc_one = runcount_length'(1);

    seg_state_t                 state, state_nxt;
    logic [runcount_length-1:0] remaining, remaining_nxt;
    logic                       eol_q, eol_nxt;
    logic [runindex_length-1:0] idx_nxt;

    logic [runindex_length-1:0] idx_cur;
    logic [runindex_length-1:0] idx_inc;
    logic [runindex_length-1:0] idx_dec;
    logic [j_width-1:0]         j_cur;
    logic [j_width-1:0]         j_next;
    logic [runcount_length-1:0] rm_cur;
    logic [runcount_length-1:0] rm_next;
    logic [runcount_length-1:0] rem_after_seg;

    logic                       ready_c;
    logic                       valid_c;
    logic [tok_width-1:0]       bits_c;
    logic [tok_len_width-1:0]   len_c;
    logic                       done_c;

    // Only the look-ahead segment size is needed; its J is not.
    logic unused_j_next;
    assign unused_j_next = ^j_next;

    function automatic logic [runindex_length-1:0] sat_inc(input logic [runindex_length-1:0] idx);
        return (idx == runindex_max) ? idx : idx + runindex_length'(1);
    endfunction

    function automatic logic [runindex_length-1:0] sat_dec(input logic [runindex_length-1:0] idx);
        return (idx == '0) ? idx : idx - runindex_length'(1);
    endfunction

    // Picks the phase that follows, so each phase presents its token in its
    // first cycle: more segments, interruption, EOL token, or nothing left.
    function automatic seg_state_t next_phase(input logic [runcount_length-1:0] rem,
                                              input logic [runcount_length-1:0] rm,
                                              input logic                       eol);
        if (rem >= rm) begin
            return ST_SEG;
        end else if (!eol) begin
            return ST_INT;
        end else if (rem == '0) begin
            return ST_FIN;
        end else begin
            return ST_EOL;
        end
    endfunction

    // Current index (with the IDLE-only clear applied first) and its
    // saturating neighbours used for segment and interruption updates.
    always_comb begin
        idx_cur       = (state == ST_IDLE && index_clear) ? '0 : run_index;
        idx_inc       = sat_inc(run_index);
        idx_dec       = sat_dec(run_index);
        rem_after_seg = remaining - rm_cur;
    end

    run_j_table u_j_cur (
        .run_index (idx_cur),
        .j         (j_cur),
        .rm        (rm_cur)
    );

    run_j_table u_j_next (
        .run_index (idx_inc),
        .j         (j_next),
        .rm        (rm_next)
    );

    // Next-state, datapath updates and token presentation.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        eol_nxt       = eol_q;
        idx_nxt       = run_index;
        ready_c       = 1'b0;
        valid_c       = 1'b0;
        bits_c        = '0;
        len_c         = '0;
        done_c        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                idx_nxt = idx_cur;
                if (run_valid) begin
                    remaining_nxt = run_length;
                    eol_nxt       = run_eol;
                    state_nxt     = next_phase(run_length, rm_cur, run_eol);
                end
            end
            ST_SEG: begin
                if (remaining >= rm_cur) begin
                    valid_c = 1'b1;
                    bits_c  = tok_width'(1);
                    len_c   = tok_len_width'(1);
                    if (tok_ready) begin
                        remaining_nxt = rem_after_seg;
                        idx_nxt       = idx_inc;
                        state_nxt     = next_phase(rem_after_seg, rm_next, eol_q);
                    end
                end else begin
                    state_nxt = eol_q ? ST_EOL : ST_INT;
                end
            end
            ST_EOL: begin
                if (remaining != '0) begin
                    valid_c = 1'b1;
                    bits_c  = tok_width'(1);
                    len_c   = tok_len_width'(1);
                    if (tok_ready) begin
                        state_nxt = ST_FIN;
                    end
                end else begin
                    state_nxt = ST_FIN;
                end
            end
            ST_INT: begin
                // Leading '0' is implicit: remaining < rm keeps bit J clear.
                valid_c = 1'b1;
                bits_c  = {1'b0, remaining & (rm_cur - rc_one)};
                len_c   = {1'b0, j_cur} + tok_len_width'(1);
                if (tok_ready) begin
                    idx_nxt   = idx_dec;
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        run_ready = reset_n & ready_c;
        tok_valid = reset_n & valid_c;
        tok_bits  = reset_n ? bits_c : '0;
        tok_len   = reset_n ? len_c : '0;
        run_done  = reset_n & done_c;
    end

    // State, RUNindex and remaining-count registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            run_index <= '0;
            remaining <= '0;
            eol_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_index <= idx_nxt;
            remaining <= remaining_nxt;
            eol_q     <= eol_nxt;
        end
    end

endmodule
